cpsum_axis_serializer: RTL and testbench

Transmit-side counterpart of the activation/weight/index AXIS input FIFOs. It captures the full-width partial-sum vector from the accelerator core when the finish pulse fires, then streams it out as 64-bit AXIS beats, LSB chunk first, with TLAST on the final beat. It sits between the core's `o_cpsum`/`o_finish` outputs and the cpsum output FIFO. Every bit of the result is exported, not just the low 64.

---
 rtl/cnn_axis_pkg.sv | 13 +
 rtl/cpsum_axis_serializer.sv | 111 +++++++++++
 tb/tb_cpsum_axis_serializer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_axis_pkg.sv
// rtl/cnn_axis_pkg.sv - shared AXIS widths and serializer state encoding
package cnn_axis_pkg;

  localparam int BEAT_W    = 64;
  localparam int CPSUM_W   = 19712;
  localparam int NUM_BEATS = CPSUM_W / BEAT_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/cpsum_axis_serializer.sv
// rtl/cpsum_axis_serializer.sv - captures the core's partial-sum vector on finish
// and streams it out as BEAT_W-wide AXIS beats, LSB chunk first, TLAST on the final beat
module cpsum_axis_serializer #(
  parameter int CPSUM_W = cnn_axis_pkg::CPSUM_W,
  parameter int BEAT_W  = cnn_axis_pkg::BEAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CPSUM_W-1:0] i_cpsum,
  input  logic               i_finish,
  output logic [BEAT_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               o_busy,
  output logic               o_overflow
);

  import cnn_axis_pkg::state_e;
  import cnn_axis_pkg::ST_IDLE;
  import cnn_axis_pkg::ST_SEND;

  localparam int NUM_BEATS = CPSUM_W / BEAT_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  if (CPSUM_W % BEAT_W != 0) begin : g_width_check
    $fatal(1, "CPSUM_W must be an integer multiple of BEAT_W");
  end

  state_e             state_q, state_d;
  logic [CPSUM_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               overflow_q, overflow_d;

  logic sending;
  logic handshake;
  logic last_beat;

  assign sending   = (state_q == ST_SEND);
  assign handshake = sending & m_axis_tready;
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  // The frame register shifts right by one beat per handshake, so the current
  // beat is always the low BEAT_W bits and no wide output mux is needed.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    beat_cnt_d = beat_cnt_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (i_finish) begin
          frame_d    = i_cpsum;
          beat_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (handshake && last_beat) begin
          beat_cnt_d = '0;
          if (i_finish) begin
            frame_d = i_cpsum;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (handshake) begin
            frame_d    = frame_q >> BEAT_W;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
          // A finish that cannot be accepted without a bubble is dropped.
          if (i_finish) begin
            overflow_d = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage is qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign m_axis_tvalid = sending;
  assign m_axis_tdata  = sending ? frame_q[BEAT_W-1:0] : '0;
  assign m_axis_tlast  = sending & last_beat;
  assign o_busy        = sending;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_cpsum_axis_serializer.sv
// tb/tb_cpsum_axis_serializer.sv - directed self-checking bench for cpsum_axis_serializer
module tb_cpsum_axis_serializer;

  localparam int CW = 19712;
  localparam int BW = 64;
  localparam int NB = 308;

  logic          clk;
  logic          rst;
  logic [CW-1:0] i_cpsum;
  logic          i_finish;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          o_busy;
  logic          o_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cpsum_axis_serializer #(.CPSUM_W(CW), .BEAT_W(BW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cpsum       (i_cpsum),
    .i_finish      (i_finish),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] make_frame(input logic [63:0] hi);
    logic [CW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[i*BW +: BW] = hi | 64'(i);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [CW-1:0] f);
    i_cpsum  = f;
    i_finish = 1'b1;
    step();
    i_finish = 1'b0;
  endtask

  // Entered with beat 0 already visible; returns just after the final handshake edge.
  task automatic recv_frame(input logic [63:0] hi, input bit bp, input int pulse_at,
                            input logic [CW-1:0] pulse_frame, input bit pulse_is_ovf,
                            input logic ovf_in);
    int   k = 0;
    int   cyc = 0;
    bit   pulsed;
    bit   pulse_done = 0;
    logic ovf_exp = ovf_in;
    while (k < NB && cyc < 4*NB) begin
      m_axis_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      pulsed = (k == pulse_at) && m_axis_tready && !pulse_done;
      if (pulsed) begin
        i_cpsum    = pulse_frame;
        i_finish   = 1'b1;
        pulse_done = 1;
      end
      check("beat_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("beat_tdata", m_axis_tdata, hi | 64'(k));
      check("beat_tlast", 64'(m_axis_tlast), 64'(k == NB-1));
      check("beat_busy", 64'(o_busy), 64'd1);
      check("beat_overflow", 64'(o_overflow), 64'(ovf_exp));
      if (m_axis_tready) k++;
      step();
      cyc++;
      i_finish = 1'b0;
      if (pulsed && pulse_is_ovf) ovf_exp = 1'b1;
    end
    check("frame_handshakes", 64'(k), 64'(NB));
  endtask

  task automatic check_idle(input string tag, input logic ovf);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    check({tag, "_tdata"}, m_axis_tdata, 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_overflow"}, 64'(o_overflow), 64'(ovf));
  endtask

  initial begin
    logic [CW-1:0] frame_a;
    logic [CW-1:0] frame_b;
    logic [CW-1:0] frame_c;
    logic [CW-1:0] frame_x;
    frame_a = make_frame(64'h0);
    frame_b = make_frame(64'hFFFF_0000_0000_0000);
    frame_c = make_frame(64'h1234_5678_0000_0000);
    frame_x = make_frame(64'hDEAD_BEEF_0000_0000);

    rst           = 1'b0;
    i_cpsum       = '0;
    i_finish      = 1'b0;
    m_axis_tready = 1'b0;
    step();
    step();
    check_idle("reset", 1'b0);
    rst = 1'b1;
    step();
    check_idle("post_reset", 1'b0);

    // Basic frame with tready held high.
    m_axis_tready = 1'b1;
    start_frame(frame_a);
    recv_frame(64'h0, 1'b0, -1, frame_x, 1'b0, 1'b0);
    check_idle("basic_end", 1'b0);

    // Backpressure: tready pattern 1,0,0,1.
    start_frame(frame_a);
    recv_frame(64'h0, 1'b1, -1, frame_x, 1'b0, 1'b0);
    check_idle("bp_end", 1'b0);

    // Back-to-back: B's finish coincides with A's last handshake.
    m_axis_tready = 1'b1;
    start_frame(frame_a);
    recv_frame(64'h0, 1'b0, NB-1, frame_b, 1'b0, 1'b0);
    recv_frame(64'hFFFF_0000_0000_0000, 1'b0, -1, frame_x, 1'b0, 1'b0);
    check_idle("b2b_end", 1'b0);

    // Overflow: a second finish at beat 100 is dropped and flagged.
    start_frame(frame_a);
    recv_frame(64'h0, 1'b0, 100, frame_x, 1'b1, 1'b0);
    check_idle("ovf_end", 1'b1);
    step();
    check("ovf_sticky", 64'(o_overflow), 64'd1);

    // Reset asserted at beat 50.
    m_axis_tready = 1'b1;
    start_frame(frame_a);
    repeat (50) step();
    check("rst_pre_tdata", m_axis_tdata, 64'd50);
    check("rst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst = 1'b0;
    #1;
    check_idle("rst_async", 1'b0);
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_after_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_after_busy", 64'(o_busy), 64'd0);
    end
    start_frame(frame_c);
    recv_frame(64'h1234_5678_0000_0000, 1'b0, -1, frame_x, 1'b0, 1'b0);
    check_idle("rst_frame_end", 1'b0);

    // Idle stability with tready high.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("idle_busy", 64'(o_busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
